// File: rtl/branch_pkg.sv
// Shared encodings and types for the branch resolve unit: condition codes,
// 2-bit BHT counter states, the Z/N/C flag triple and condition evaluation.
package branch_pkg;

    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_CS     = 3'd2;
    localparam logic [2:0] COND_CC     = 3'd3;
    localparam logic [2:0] COND_MI     = 3'd4;
    localparam logic [2:0] COND_PL     = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    localparam logic [1:0] CTR_SNT   = 2'd0;
    localparam logic [1:0] CTR_WNT   = 2'd1;
    localparam logic [1:0] CTR_WT    = 2'd2;
    localparam logic [1:0] CTR_ST    = 2'd3;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
    } flags_t;

    function automatic logic eval_cond(input logic [2:0] cond, input flags_t f);
        logic r;
        case (cond)
            COND_EQ:     r = f.z;
            COND_NE:     r = !f.z;
            COND_CS:     r = f.c;
            COND_CC:     r = !f.c;
            COND_MI:     r = f.n;
            COND_PL:     r = !f.n;
            COND_ALWAYS: r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port for fetch lookup and one write port that applies a taken/not-taken step.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0] ctr_q [DEPTH];
    logic [1:0] cur_ctr;
    logic [1:0] nxt_ctr;

    always_comb begin
        cur_ctr = ctr_q[wr_idx];
        nxt_ctr = cur_ctr;
        if (wr_taken) begin
            if (cur_ctr != CTR_ST) nxt_ctr = cur_ctr + 2'd1;
        end else begin
            if (cur_ctr != CTR_SNT) nxt_ctr = cur_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RESET;
        end else if (wr_en) begin
            ctr_q[wr_idx] <= nxt_ctr;
        end
    end

    // Reads the pre-edge state: an update in flight is not forwarded.
    assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves decode-stage conditional branches against per-accumulator flags,
// trains the BHT used by fetch and counts mispredicts.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int NUM_ACC   = 2,
    parameter int ACC_SEL_W = 3,
    parameter int PC_W      = 16,
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ACC-1:0]   flag_we,
    input  logic [NUM_ACC-1:0]   flag_z_in,
    input  logic [NUM_ACC-1:0]   flag_n_in,
    input  logic [NUM_ACC-1:0]   flag_c_in,
    input  logic                 br_valid,
    input  logic [2:0]           br_cond,
    input  logic [ACC_SEL_W-1:0] br_acc,
    input  logic [PC_W-1:0]      br_pc,
    input  logic                 br_pred_taken,
    input  logic                 flush,
    input  logic [PC_W-1:0]      lk_pc,
    output logic                 lk_taken,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 res_mispredict,
    output logic [PC_W-1:0]      res_pc,
    output logic                 res_illegal,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     mispredict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    flags_t flag_q [NUM_ACC];
    flags_t eff_flags;
    logic   acc_legal;
    logic   accept;
    logic   taken;
    logic   mispredict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) flag_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (flag_we[i]) flag_q[i] <= {flag_z_in[i], flag_n_in[i], flag_c_in[i]};
            end
        end
    end

    // Extra top bit keeps the compare correct when NUM_ACC == 2**ACC_SEL_W.
    assign acc_legal = {1'b0, br_acc} < (ACC_SEL_W + 1)'(NUM_ACC);

    always_comb begin
        eff_flags = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (acc_legal && br_acc == ACC_SEL_W'(i)) begin
                eff_flags = flag_we[i] ? {flag_z_in[i], flag_n_in[i], flag_c_in[i]} : flag_q[i];
            end
        end
    end

    assign accept     = br_valid && !flush;
    assign taken      = acc_legal && eval_cond(br_cond, eff_flags);
    assign mispredict = taken != br_pred_taken;

    // res_valid is a single-cycle pulse with no ready: the consumer must take
    // the result in the cycle it is presented; res_taken/res_pc then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
            res_pc         <= '0;
            res_illegal    <= 1'b0;
        end else begin
            res_valid      <= accept;
            res_mispredict <= accept && mispredict;
            res_illegal    <= accept && !acc_legal;
            if (accept) begin
                res_taken <= taken;
                res_pc    <= br_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (cnt_clr) begin
            mispredict_cnt <= '0;
        end else if (accept && mispredict && mispredict_cnt != CNT_MAX) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

    logic unused_pc_hi;
    assign unused_pc_hi = ^{lk_pc[PC_W-1:BHT_IDX_W], br_pc[PC_W-1:BHT_IDX_W]};

    bht_2bit #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (lk_pc[BHT_IDX_W-1:0]),
        .rd_taken(lk_taken),
        .wr_en   (accept && acc_legal),
        .wr_idx  (br_pc[BHT_IDX_W-1:0]),
        .wr_taken(taken)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever res_valid is presented.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int NUM_ACC   = 2;
    localparam int ACC_SEL_W = 3;
    localparam int PC_W      = 16;
    localparam int BHT_IDX_W = 4;
    localparam int CNT_W     = 16;
    localparam int W         = PC_W + 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_ACC-1:0]   flag_we = '0;
    logic [NUM_ACC-1:0]   flag_z_in = '0;
    logic [NUM_ACC-1:0]   flag_n_in = '0;
    logic [NUM_ACC-1:0]   flag_c_in = '0;
    logic                 br_valid = 1'b0;
    logic [2:0]           br_cond = '0;
    logic [ACC_SEL_W-1:0] br_acc = '0;
    logic [PC_W-1:0]      br_pc = '0;
    logic                 br_pred_taken = 1'b0;
    logic                 flush = 1'b0;
    logic [PC_W-1:0]      lk_pc = '0;
    logic                 lk_taken;
    logic                 res_valid;
    logic                 res_taken;
    logic                 res_mispredict;
    logic [PC_W-1:0]      res_pc;
    logic                 res_illegal;
    logic                 cnt_clr = 1'b0;
    logic [CNT_W-1:0]     mispredict_cnt;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    branch_resolve_unit #(
        .NUM_ACC(NUM_ACC), .ACC_SEL_W(ACC_SEL_W), .PC_W(PC_W),
        .BHT_IDX_W(BHT_IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .flag_we(flag_we), .flag_z_in(flag_z_in), .flag_n_in(flag_n_in), .flag_c_in(flag_c_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_acc(br_acc), .br_pc(br_pc),
        .br_pred_taken(br_pred_taken), .flush(flush),
        .lk_pc(lk_pc), .lk_taken(lk_taken),
        .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
        .res_pc(res_pc), .res_illegal(res_illegal),
        .cnt_clr(cnt_clr), .mispredict_cnt(mispredict_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one decode cycle, called at a negedge, returns at the next negedge
    task automatic drive(input logic v, input logic fl, input logic [2:0] cond,
                         input logic [ACC_SEL_W-1:0] acc, input logic [PC_W-1:0] pc,
                         input logic pred, input logic e_taken, input logic e_ill);
        br_valid      = v;
        flush         = fl;
        br_cond       = cond;
        br_acc        = acc;
        br_pc         = pc;
        br_pred_taken = pred;
        if (v && !fl) exp_q.push_back({e_taken, e_taken != pred, e_ill, pc});
        @(negedge clk);
        br_valid = 1'b0;
        flush    = 1'b0;
        flag_we  = '0;
        cnt_clr  = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, COND_NEVER, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", 32'(res_valid), 32'd0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("res_taken", 32'(res_taken), 32'(e[W-1]));
                    check("res_mispredict", 32'(res_mispredict), 32'(e[W-2]));
                    check("res_illegal", 32'(res_illegal), 32'(e[W-3]));
                    check("res_pc", 32'(res_pc), 32'(e[PC_W-1:0]));
                end
            end else begin
                check("idle_mispredict", 32'(res_mispredict), 32'd0);
                check("idle_illegal", 32'(res_illegal), 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] sweep_exp;
        logic [5:0] sat_lk;

        #3;
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_cnt", 32'(mispredict_cnt), 32'd0);
        lk_pc = 16'h0005;
        #1;
        check("reset_lk", 32'(lk_taken), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // flag bypass on acc1
        flag_we   = 2'b10;
        flag_z_in = 2'b10;
        drive(1'b1, 1'b0, COND_EQ, 3'd1, 16'h0100, 1'b1, 1'b1, 1'b0);
        flag_z_in = '0;

        // acc0: Z=0 N=1 C=1, then sweep conditions 0..7
        flag_we   = 2'b01;
        flag_n_in = 2'b01;
        flag_c_in = 2'b01;
        idle();
        sweep_exp = 8'h56;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'(i), 3'd0, 16'h0208 + 16'(i), sweep_exp[i], sweep_exp[i], 1'b0);
        end

        // BHT saturation at index 5
        lk_pc = 16'h0005;
        #1;
        check("bht_initial", 32'(lk_taken), 32'd0);
        @(negedge clk);
        sat_lk = 6'b011111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, COND_ALWAYS, 3'd0, 16'h0005, 1'b1, 1'b1, 1'b0);
            check("bht_taken_step", 32'(lk_taken), 32'(sat_lk[i]));
        end
        for (int i = 4; i < 6; i++) begin
            drive(1'b1, 1'b0, COND_NEVER, 3'd0, 16'h0005, 1'b0, 1'b0, 1'b0);
            check("bht_nottaken_step", 32'(lk_taken), 32'(sat_lk[i]));
        end
        lk_pc = 16'h0015;
        #1;
        check("bht_alias_read", 32'(lk_taken), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, COND_ALWAYS, 3'd0, 16'h0015, 1'b1, 1'b1, 1'b0);
        lk_pc = 16'h0005;
        #1;
        check("bht_alias_write", 32'(lk_taken), 32'd1);
        check("cnt_no_mispredicts", 32'(mispredict_cnt), 32'd0);

        // mispredict counting and clear priority
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, COND_ALWAYS, 3'd0, 16'h0040, 1'b0, 1'b1, 1'b0);
        end
        check("cnt_three", 32'(mispredict_cnt), 32'd3);
        cnt_clr = 1'b1;
        drive(1'b1, 1'b0, COND_ALWAYS, 3'd0, 16'h0040, 1'b0, 1'b1, 1'b0);
        check("cnt_clr_priority", 32'(mispredict_cnt), 32'd0);
        drive(1'b1, 1'b0, COND_ALWAYS, 3'd0, 16'h0040, 1'b0, 1'b1, 1'b0);
        check("cnt_after_clr", 32'(mispredict_cnt), 32'd1);

        // flush: no result, no BHT update, no count
        lk_pc = 16'h0007;
        drive(1'b1, 1'b1, COND_ALWAYS, 3'd0, 16'h0007, 1'b0, 1'b1, 1'b0);
        check("flush_bht", 32'(lk_taken), 32'd0);
        check("flush_cnt", 32'(mispredict_cnt), 32'd1);

        // illegal accumulator: taken forced 0, BHT untouched
        lk_pc = 16'h0009;
        drive(1'b1, 1'b0, COND_ALWAYS, 3'd0, 16'h0009, 1'b1, 1'b1, 1'b0);
        check("illegal_setup_bht", 32'(lk_taken), 32'd1);
        drive(1'b1, 1'b0, COND_ALWAYS, 3'd7, 16'h0009, 1'b1, 1'b0, 1'b1);
        check("illegal_bht", 32'(lk_taken), 32'd1);
        check("illegal_cnt", 32'(mispredict_cnt), 32'd2);
        idle();

        // async reset while a result is presented
        br_valid      = 1'b1;
        br_cond       = COND_ALWAYS;
        br_acc        = 3'd0;
        br_pc         = 16'h0033;
        br_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        check("pre_reset_valid", 32'(res_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_res_valid", 32'(res_valid), 32'd0);
        check("async_res_mispredict", 32'(res_mispredict), 32'd0);
        check("async_cnt", 32'(mispredict_cnt), 32'd0);
        for (int i = 0; i < 16; i++) begin
            lk_pc = 16'(i);
            #0.1;
            check("async_lk", 32'(lk_taken), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        idle();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the combinational branch-condition check.
- Holds registered Z/N/C flags for NUM_ACC accumulators and forwards same-cycle flag writes.
- Resolves conditional branches against the selected accumulator's flags, producing a registered result with 1-cycle latency.
- Maintains a 2-bit saturating branch history table (BHT) for fetch-stage prediction, detects mispredicts, and counts them; sits between the decode stage and fetch/PC logic.

Parameters:
- NUM_ACC, 2, number of accumulators with flag sets (legal 2..8)
- ACC_SEL_W, 3, width of the accumulator select field
- PC_W, 16, program-counter width
- BHT_IDX_W, 4, BHT index width; table depth = 2**BHT_IDX_W, indexed by pc[BHT_IDX_W-1:0]
- CNT_W, 16, mispredict counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flag_we  in  NUM_ACC  per-accumulator flag write enable
- flag_z_in  in  NUM_ACC  zero flag value per accumulator
- flag_n_in  in  NUM_ACC  sign flag value per accumulator
- flag_c_in  in  NUM_ACC  carry flag value per accumulator
- br_valid  in  1  branch present in decode this cycle
- br_cond  in  3  condition: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 ALWAYS, 7 NEVER
- br_acc  in  ACC_SEL_W  accumulator select
- br_pc  in  PC_W  PC of the branch
- br_pred_taken  in  1  prediction fetch used for this branch
- flush  in  1  kill the branch in decode this cycle
- lk_pc  in  PC_W  fetch lookup PC
- lk_taken  out  1  prediction for lk_pc (combinational: BHT[lk_pc] MSB)
- res_valid  out  1  resolution valid
- res_taken  out  1  resolved outcome
- res_mispredict  out  1  res_taken != registered br_pred_taken
- res_pc  out  PC_W  PC of the resolved branch
- res_illegal  out  1  br_acc >= NUM_ACC
- cnt_clr  in  1  synchronous clear of the mispredict counter
- mispredict_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, immediate): all flags 0; all BHT entries 2'b01 (weakly not-taken); res_* 0; mispredict_cnt 0.
- Flag registers: on a clock edge with flag_we[i]=1, set Z/N/C[i] from flag_*_in[i].
- Effective flags for resolution:
  - If flag_we[br_acc]=1 in the same cycle, use flag_*_in[br_acc] (bypass).
  - Otherwise use the registered flags.
- Condition evaluation:
  - EQ: Z=1; NE: Z=0; CS: C=1; CC: C=0; MI: N=1; PL: N=0; ALWAYS: 1; NEVER: 0.
- Illegal select: br_acc >= NUM_ACC forces taken=0 and res_illegal=1. The BHT is not updated; the mispredict check still applies.
- Latency and result register:
  - A branch with br_valid=1 and flush=0 in cycle t gives res_valid=1 in cycle t+1, with res_taken, res_pc, res_mispredict and res_illegal registered together.
  - With no valid branch, res_valid=0 next cycle. The other res_* fields hold their last values, except res_mispredict and res_illegal, which are 0.
- flush=1 overrides br_valid: no result, no BHT update, no count.
- BHT update, at the edge that registers the result, for legal branches only:
  - Taken: counter +1, saturating at 3.
  - Not taken: counter -1, saturating at 0.
- Lookup/update timing:
  - lk_taken in cycle t reflects BHT state before that cycle's update edge.
  - A lookup of the same index in cycle t+1 sees the new value.
  - No bypass of the pending update.
- Mispredict counter:
  - Increments at the same edge when a mispredict is registered; saturates at 2**CNT_W-1.
  - cnt_clr has priority over increment; clearing and counting in the same cycle leaves 0.
- Back-to-back branches every cycle are supported. Two branches to the same BHT index in consecutive cycles apply both updates in order.
- A reset asserted mid-operation discards any in-flight result in the same cycle.

Decomposition:
- Shared package branch_pkg holds:
  - Condition encodings COND_EQ..COND_NEVER.
  - BHT counter constants: CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3, CTR_RESET=CTR_WNT.
  - A flag-triple struct {z, n, c}.
- One sub-module: bht_2bit. It holds the table, the combinational read port, a single write port, and the saturating update logic. The top level holds the flags, bypass, condition logic, result register and counter.

Test Plan:
- Flag bypass: with acc1 flags all 0, in the same cycle drive flag_we=2'b10, flag_z_in=2'b10, br_valid=1, cond EQ, br_acc=1 -> next cycle res_valid=1, res_taken=1.
- Condition sweep: acc0 Z=0 N=1 C=1, then cond 0..7 on consecutive cycles -> res_taken sequence 0,1,1,0,1,0,1,0.
- BHT saturation: pc=0x0005, four taken branches back-to-back -> lk_taken(0x0005) goes 0 then 1 (after 1st), counter reaches 3. Two not-taken branches -> lk_taken=0 only after the 2nd. Index 0x0015 aliases to the same entry.
- Mispredict count: br_pred_taken=0 on 3 taken branches -> res_mispredict=1 each, mispredict_cnt=3. Assert cnt_clr alongside a 4th mispredict -> count 0.
- Flush and illegal: flush=1 with br_valid=1 -> res_valid=0, BHT and count unchanged. br_acc=7 with NUM_ACC=2 -> res_illegal=1, res_taken=0, BHT unchanged.
- Async reset mid-stream: assert rst between clock edges while res_valid=1 -> res_valid=0 immediately, lk_taken=0 for all PCs, mispredict_cnt=0.
